// File: rtl/mem_port2_arbiter_pkg.sv
// Shared types and constants for the RAM data-port (port 2) arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {NORMAL, DRAIN, LOCKED} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_PROG} owner_t;

    typedef logic [1:0] mem_size_t;
    localparam mem_size_t SZ_BYTE = 2'd0;
    localparam mem_size_t SZ_HALF = 2'd1;
    localparam mem_size_t SZ_WORD = 2'd2;

    localparam logic [31:0] IO_BASE = 32'h1100_0000;

endpackage

// File: rtl/mem_port2_arbiter.sv
// Shares RAM port 2 between the CPU load/store stage and the program loader,
// with bounded loader starvation and a drained exclusive lock for bulk loads.
module mem_port2_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic        i_mem_clk,
    input  logic        i_rst_n,

    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic [1:0]  i_cpu_size,
    input  logic        i_cpu_sign,
    output logic        o_cpu_gnt,
    output logic        o_cpu_rvalid,
    output logic [31:0] o_cpu_rdata,

    input  logic        i_prog_req,
    input  logic        i_prog_we,
    input  logic [31:0] i_prog_addr,
    input  logic [31:0] i_prog_wdata,
    input  logic [1:0]  i_prog_size,
    input  logic        i_prog_sign,
    output logic        o_prog_gnt,
    output logic        o_prog_rvalid,
    output logic [31:0] o_prog_rdata,

    input  logic        i_prog_lock,
    output logic        o_locked,

    output logic [31:0] o_mem_addr2,
    output logic [31:0] o_mem_din2,
    output logic [1:0]  o_mem_size,
    output logic        o_mem_sign,
    output logic        o_mem_write2,
    output logic        o_mem_read2,
    input  logic [31:0] i_mem_dout2
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    arb_state_t     r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_locked;
    logic           r_rsp_valid;
    owner_t         r_rsp_owner;

    logic w_cpu_gnt;
    logic w_prog_gnt;

    // Grants are gated by reset so every grant reads 0 while reset is held.
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_prog_gnt = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                NORMAL: begin
                    if (!i_prog_lock) begin
                        if (i_cpu_req && i_prog_req) begin
                            if (r_wait_cnt == WCW'(MAX_WAIT)) w_prog_gnt = 1'b1;
                            else                              w_cpu_gnt  = 1'b1;
                        end else begin
                            w_cpu_gnt  = i_cpu_req;
                            w_prog_gnt = i_prog_req;
                        end
                    end
                end
                LOCKED:  w_prog_gnt = i_prog_lock & i_prog_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_mem_addr2  = '0;
        o_mem_din2   = '0;
        o_mem_size   = '0;
        o_mem_sign   = 1'b0;
        o_mem_write2 = 1'b0;
        o_mem_read2  = 1'b0;
        if (w_cpu_gnt) begin
            o_mem_addr2  = i_cpu_addr;
            o_mem_din2   = i_cpu_wdata;
            o_mem_size   = i_cpu_size;
            o_mem_sign   = i_cpu_sign;
            o_mem_write2 = i_cpu_we;
            o_mem_read2  = ~i_cpu_we;
        end else if (w_prog_gnt) begin
            o_mem_addr2  = i_prog_addr;
            o_mem_din2   = i_prog_wdata;
            o_mem_size   = i_prog_size;
            o_mem_sign   = i_prog_sign;
            o_mem_write2 = i_prog_we;
            o_mem_read2  = ~i_prog_we;
        end
    end

    always_ff @(posedge i_mem_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= NORMAL;
            r_locked    <= 1'b0;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= OWN_CPU;
        end else begin
            r_rsp_valid <= o_mem_read2;
            if (o_mem_read2) r_rsp_owner <= w_prog_gnt ? OWN_PROG : OWN_CPU;

            case (r_state)
                NORMAL: begin
                    if (i_prog_lock) r_state <= DRAIN;
                    if (w_prog_gnt)
                        r_wait_cnt <= '0;
                    else if (i_prog_req && r_wait_cnt != WCW'(MAX_WAIT))
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                end
                // One idle cycle lets a read issued just before the lock return.
                DRAIN: begin
                    r_state    <= LOCKED;
                    r_locked   <= 1'b1;
                    r_wait_cnt <= '0;
                end
                LOCKED: begin
                    r_wait_cnt <= '0;
                    if (!i_prog_lock) begin
                        r_state  <= NORMAL;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= NORMAL;
                    r_locked   <= 1'b0;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign o_cpu_gnt     = w_cpu_gnt;
    assign o_prog_gnt    = w_prog_gnt;
    assign o_locked      = r_locked;
    assign o_cpu_rvalid  = r_rsp_valid && (r_rsp_owner == OWN_CPU);
    assign o_prog_rvalid = r_rsp_valid && (r_rsp_owner == OWN_PROG);
    assign o_cpu_rdata   = o_cpu_rvalid  ? i_mem_dout2 : '0;
    assign o_prog_rdata  = o_prog_rvalid ? i_mem_dout2 : '0;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Bench for mem_port2_arbiter: word-wide RAM model, read-response scoreboard,
// directed grant / lock / reset sequences.
module tb_mem_port2_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 0, cpu_we = 0, cpu_sign = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic [1:0]  cpu_size = 2'd2;
    logic        prog_req = 0, prog_we = 0, prog_sign = 0, prog_lock = 0;
    logic [31:0] prog_addr = 0, prog_wdata = 0;
    logic [1:0]  prog_size = 2'd2;
    logic        cpu_gnt, cpu_rvalid, prog_gnt, prog_rvalid, locked;
    logic [31:0] cpu_rdata, prog_rdata;
    logic [31:0] mem_addr2, mem_din2, mem_dout2;
    logic [1:0]  mem_size;
    logic        mem_sign, mem_write2, mem_read2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port2_arbiter #(.MAX_WAIT(4)) dut (
        .i_mem_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .i_cpu_size(cpu_size), .i_cpu_sign(cpu_sign),
        .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_prog_req(prog_req), .i_prog_we(prog_we), .i_prog_addr(prog_addr),
        .i_prog_wdata(prog_wdata), .i_prog_size(prog_size), .i_prog_sign(prog_sign),
        .o_prog_gnt(prog_gnt), .o_prog_rvalid(prog_rvalid), .o_prog_rdata(prog_rdata),
        .i_prog_lock(prog_lock), .o_locked(locked),
        .o_mem_addr2(mem_addr2), .o_mem_din2(mem_din2), .o_mem_size(mem_size),
        .o_mem_sign(mem_sign), .o_mem_write2(mem_write2), .o_mem_read2(mem_read2),
        .i_mem_dout2(mem_dout2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return (i == 64) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
    endfunction

    // RAM model: 256 words, 1-cycle read latency.
    logic [31:0] ram [256];
    bit          ram_rdy = 1'b0;
    always @(posedge clk) begin
        if (!ram_rdy) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i);
            ram_rdy <= 1'b1;
        end else begin
            if (mem_write2) ram[mem_addr2[9:2]] <= mem_din2;
            if (mem_read2)  mem_dout2 <= ram[mem_addr2[9:2]];
        end
    end

    // Scoreboard: expected response pushed when a read is accepted, popped next cycle.
    typedef struct { logic own; logic [31:0] data; } rsp_t;
    rsp_t        exp_q[$];
    logic [31:0] ref_mem [256];
    bit          ref_rdy = 1'b0;
    always @(negedge clk) begin
        rsp_t e;
        if (!ref_rdy) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
            ref_rdy = 1'b1;
        end
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_rvalid", {30'd0, cpu_rvalid, prog_rvalid}, 32'd0);
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rsp_owner", {30'd0, cpu_rvalid, prog_rvalid}, e.own ? 32'd1 : 32'd2);
                chk("rsp_data", e.own ? prog_rdata : cpu_rdata, e.data);
                chk("rsp_other0", e.own ? cpu_rdata : prog_rdata, 32'd0);
            end else begin
                chk("rvalid_idle", {30'd0, cpu_rvalid, prog_rvalid}, 32'd0);
            end
            if (cpu_gnt && cpu_req) begin
                if (cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
                else exp_q.push_back('{1'b0, ref_mem[cpu_addr[9:2]]});
            end else if (prog_gnt && prog_req) begin
                if (prog_we) ref_mem[prog_addr[9:2]] = prog_wdata;
                else exp_q.push_back('{1'b1, ref_mem[prog_addr[9:2]]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic c, input logic p);
        chk(tag, {30'd0, cpu_gnt, prog_gnt}, {30'd0, c, p});
    endtask

    initial begin
        #2;
        chk("rst_gnt", {30'd0, cpu_gnt, prog_gnt}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_memrw", {30'd0, mem_read2, mem_write2}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // CPU-only load
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        #2;
        chk_gnt("cpu_only_gnt", 1, 0);
        chk("cpu_only_addr", mem_addr2, 32'h100);
        chk("cpu_only_rd", {30'd0, mem_read2, mem_write2}, 32'd2);
        tick();
        cpu_req = 0;
        #2;
        chk("cpu_only_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("cpu_only_prv", {31'd0, prog_rvalid}, 32'd0);
        tick();

        // Both requesting: CPU x4 then loader, repeating
        cpu_req = 1; cpu_addr = 32'h200; prog_req = 1; prog_we = 0; prog_addr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk_gnt($sformatf("starve_%0d", i), (i % 5) != 4, (i % 5) == 4);
            chk($sformatf("starve_addr_%0d", i), mem_addr2, ((i % 5) == 4) ? 32'h300 : 32'h200);
            tick();
        end
        cpu_req = 0; prog_req = 0;

        // Alternating single-requester reads
        for (int i = 0; i < 6; i++) begin
            cpu_req = (i % 2) == 0; cpu_addr = 32'h10 + 32'(4 * i);
            prog_req = (i % 2) == 1; prog_addr = 32'h80 + 32'(4 * i);
            #2;
            chk_gnt($sformatf("alt_%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
        end
        cpu_req = 0; prog_req = 0;
        tick();

        // Lock sequence: CPU read in cycle 9, lock raised in cycle 10
        cpu_req = 1; cpu_addr = 32'h104;
        #2; chk_gnt("lk_c9", 1, 0);
        tick();
        prog_lock = 1; prog_req = 1; prog_we = 1; prog_addr = 32'h40; prog_wdata = 32'h1234_5678;
        #2; chk_gnt("lk_c10", 0, 0); chk("lk_c10_l", {31'd0, locked}, 32'd0);
        tick();
        #2; chk_gnt("lk_c11", 0, 0); chk("lk_c11_l", {31'd0, locked}, 32'd0);
        chk("lk_c11_rv", {31'd0, cpu_rvalid}, 32'd0);
        tick();
        #2; chk_gnt("lk_c12", 0, 1); chk("lk_c12_l", {31'd0, locked}, 32'd1);
        chk("lk_c12_wr", {30'd0, mem_read2, mem_write2}, 32'd1);
        chk("lk_c12_din", mem_din2, 32'h1234_5678);
        tick();
        prog_req = 0;
        #2; chk_gnt("lk_c13", 0, 0); chk("lk_c13_l", {31'd0, locked}, 32'd1);
        tick();
        prog_lock = 0; prog_req = 1; prog_we = 0;
        #2; chk_gnt("unlk_m", 0, 0); chk("unlk_m_l", {31'd0, locked}, 32'd1);
        tick();
        prog_req = 0; cpu_addr = 32'h40;
        #2; chk_gnt("unlk_m1", 1, 0); chk("unlk_m1_l", {31'd0, locked}, 32'd0);
        tick();
        cpu_req = 0;
        #2; chk("wr_rb", cpu_rdata, 32'h1234_5678);
        tick();

        // Lock dropped during DRAIN still passes through one LOCKED cycle
        prog_lock = 1; #2; chk_gnt("dd_n", 0, 0); tick();
        prog_lock = 0; #2; chk_gnt("dd_drain", 0, 0); chk("dd_drain_l", {31'd0, locked}, 32'd0); tick();
        #2; chk("dd_lk_l", {31'd0, locked}, 32'd1); tick();
        cpu_req = 1; cpu_addr = 32'h8;
        #2; chk("dd_norm_l", {31'd0, locked}, 32'd0); chk_gnt("dd_norm_gnt", 1, 0);
        tick();

        // Reset asserted while a read response is pending
        rst_n = 0;
        #1;
        chk("rst_mid_rv", {30'd0, cpu_rvalid, prog_rvalid}, 32'd0);
        chk("rst_mid_rdata", cpu_rdata, 32'd0);
        chk_gnt("rst_mid_gnt", 0, 0);
        chk("rst_mid_rd", {30'd0, mem_read2, mem_write2}, 32'd0);
        chk("rst_mid_addr", mem_addr2, 32'd0);
        cpu_req = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
        cpu_req = 1; cpu_addr = 32'h100;
        #2; chk_gnt("post_rst_gnt", 1, 0);
        tick();
        cpu_req = 0;
        #2; chk("post_rst_rdata", cpu_rdata, 32'hDEAD_BEEF);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
